// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and initiator FSM states shared by AHB initiators and responders.
// Constants only: no logic, no latency, no flow control.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_LAST = 2'd2,
      ST_ERR  = 2'd3
   } ahb_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: one command becomes SINGLE/INCR beats; done 3 cycles after accept for a single beat.
// hready low freezes every output and stalls pops; commands are only taken while idle.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int MAX_LEN_W = 8
) (
   input  logic                 hclk,
   input  logic                 hreset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [31:0]          cmd_addr,
   input  logic [MAX_LEN_W-1:0] cmd_len,
   input  logic [2:0]           cmd_size,
   input  logic [31:0]          wr_data,
   output logic                 wr_pop,
   output logic [31:0]          rd_data,
   output logic                 rd_valid,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           htrans,
   output logic [2:0]           hburst,
   output logic [2:0]           hsize,
   output logic                 hwrite,
   output logic [31:0]          haddr,
   output logic [31:0]          hwdata,
   input  logic                 hready,
   input  logic [31:0]          hrdata,
   input  logic                 hresp
);

   ahb_state_t           r_state;
   logic [MAX_LEN_W-1:0] r_cnt;
   logic                 r_dphase;
   logic [1:0]           r_htrans;
   logic [2:0]           r_hburst;
   logic [2:0]           r_hsize;
   logic                 r_hwrite;
   logic [31:0]          r_haddr;
   logic [31:0]          r_hwdata;
   logic [31:0]          r_rd_data;
   logic                 r_rd_valid;
   logic                 r_done;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_first_err;
   logic                 w_bnd;
   logic [31:0]          w_next;

   // Next beat address; MSB flags a 1 KB crossing, which must restart as NONSEQ.
   function automatic logic [32:0] next_beat(input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] n;
      n = addr + (32'd1 << size);
      return {(n[9:0] == 10'd0), n};
   endfunction

   assign w_accept    = (r_state == ST_ADDR) && hready;
   assign w_first_err = r_dphase && (hresp == HRESP_ERROR) && !hready;
   assign {w_bnd, w_next} = next_beat(r_haddr, r_hsize);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_dphase   <= 1'b0;
         r_htrans   <= HTRANS_IDLE;
         r_hburst   <= HBURST_SINGLE;
         r_hsize    <= HSIZE_BYTE;
         r_hwrite   <= 1'b0;
         r_haddr    <= 32'h0;
         r_hwdata   <= 32'h0;
         r_rd_data  <= 32'h0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;

         if (r_dphase && hready && (hresp == HRESP_OKAY) && !r_hwrite) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= hrdata;
         end
         if (w_accept) begin
            r_dphase <= 1'b1;
         end else if (hready) begin
            r_dphase <= 1'b0;
         end
         if (w_accept && r_hwrite) begin
            r_hwdata <= wr_data;
         end

         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_size > HSIZE_WORD) begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else begin
                     r_haddr  <= cmd_addr;
                     r_hsize  <= cmd_size;
                     r_hwrite <= cmd_write;
                     r_hburst <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
                     r_htrans <= HTRANS_NONSEQ;
                     r_cnt    <= cmd_len;
                     r_state  <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (w_first_err) begin
                  r_htrans <= HTRANS_IDLE;
                  r_state  <= ST_ERR;
               end else if (w_accept) begin
                  if (r_cnt == '0) begin
                     r_htrans <= HTRANS_IDLE;
                     r_state  <= ST_LAST;
                  end else begin
                     r_haddr  <= w_next;
                     r_htrans <= w_bnd ? HTRANS_NONSEQ : HTRANS_SEQ;
                     r_cnt    <= r_cnt - 1'b1;
                  end
               end
            end
            ST_LAST: begin
               if (w_first_err) begin
                  r_state <= ST_ERR;
               end else if (hready) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_ERR: begin
               if (hready) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign wr_pop    = w_accept && r_hwrite;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign done      = r_done;
   assign err       = r_err;
   assign htrans    = r_htrans;
   assign hburst    = r_hburst;
   assign hsize     = r_hsize;
   assign hwrite    = r_hwrite;
   assign haddr     = r_haddr;
   assign hwdata    = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small word-RAM responder and scripted hready/hresp.
// Inputs change 1 ns after the rising edge; beats, pops and read data are logged on the falling edge.
module tb_ahb_lite_master;
   import ahb_pkg::*;

   logic        hclk, hreset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [31:0] wr_data, rd_data, haddr, hwdata, hrdata;
   logic        wr_pop, rd_valid, done, err, hwrite, hready, hresp;
   logic [1:0]  htrans;
   logic [2:0]  hburst, hsize;

   int          n_chk, n_fail, pops, lat;
   logic        got_err;
   logic [31:0] ap_addr_q[$];
   logic [1:0]  ap_trans_q[$];
   logic [31:0] rd_q[$];
   logic [2:0]  first_burst, first_size;
   logic        first_write;

   logic [31:0] mem [0:1023];
   logic        bp_dp, bp_wr;
   logic [31:0] bp_addr;

   ahb_lite_master #(.MAX_LEN_W(8)) dut (
      .hclk(hclk), .hreset_n(hreset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .err(err), .htrans(htrans), .hburst(hburst), .hsize(hsize),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready(hready),
      .hrdata(hrdata), .hresp(hresp)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Word RAM responder; wait and error timing comes from the stimulus.
   always @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         bp_dp   <= 1'b0;
         bp_wr   <= 1'b0;
         bp_addr <= 32'h0;
      end else if (hready) begin
         if (bp_dp && bp_wr && !hresp) mem[bp_addr[11:2]] = hwdata;
         bp_dp   <= htrans[1];
         bp_addr <= haddr;
         bp_wr   <= hwrite;
      end
   end
   assign hrdata = bp_dp ? mem[bp_addr[11:2]] : 32'h0;

   always @(negedge hclk) begin
      if (hreset_n) begin
         if (hready && htrans[1]) begin
            if (ap_addr_q.size() == 0) begin
               first_burst = hburst;
               first_size  = hsize;
               first_write = hwrite;
            end
            ap_addr_q.push_back(haddr);
            ap_trans_q.push_back(htrans);
         end
         if (wr_pop) pops++;
         if (rd_valid) rd_q.push_back(rd_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic check_beat(input int i, input logic [31:0] a, input logic [1:0] t);
      if (i < ap_addr_q.size()) begin
         chk("beat_addr", ap_addr_q[i], a);
         chk("beat_trans", 32'(ap_trans_q[i]), 32'(t));
      end
   endtask

   // Issue one command and run until done; stall window and ERROR cycle are relative to accept.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int stall_at, input int stall_len,
                          input int err_at, output int l, output logic e);
      logic        prev_stall, popped;
      logic [31:0] prev_addr;
      logic [1:0]  prev_trans;
      ap_addr_q.delete();
      ap_trans_q.delete();
      rd_q.delete();
      pops       = 0;
      cmd_write  = wr;
      cmd_addr   = addr;
      cmd_len    = len;
      cmd_size   = size;
      cmd_valid  = 1'b1;
      hready     = 1'b1;
      hresp      = 1'b0;
      #1;
      chk("cmd_ready", 32'(cmd_ready), 32'd1);
      l          = 0;
      e          = 1'b0;
      prev_stall = 1'b0;
      popped     = 1'b0;
      prev_addr  = 32'h0;
      prev_trans = 2'b00;
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (popped) wr_data = wr_data + 32'h0101_0101;
         if (done) begin
            l = k;
            e = err;
            break;
         end
         hready = !((k >= stall_at && k < stall_at + stall_len) || k == err_at);
         hresp  = (k == err_at) || (k == err_at + 1);
         #1;
         if (prev_stall) begin
            chk("hold_haddr", haddr, prev_addr);
            chk("hold_htrans", 32'(htrans), 32'(prev_trans));
         end
         if (k == err_at + 1) chk("err_htrans_idle", 32'(htrans), 32'(HTRANS_IDLE));
         prev_stall = !hready && !hresp;
         prev_addr  = haddr;
         prev_trans = htrans;
         popped     = wr_pop;
         tick();
      end
      if (l == 0) chk("done_timeout", 32'd0, 32'd1);
      hready = 1'b1;
      hresp  = 1'b0;
      tick();
   endtask

   initial begin
      n_chk = 0; n_fail = 0; pops = 0;
      hreset_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
      cmd_len = 8'h0; cmd_size = 3'h0; wr_data = 32'h0; hready = 1'b1; hresp = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[128 + i] = 32'hA0A0_0000 + 32'(i);

      #2 hreset_n = 1'b0;
      #1;
      chk("rst_htrans", 32'(htrans), 32'd0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_ctrl", {25'd0, hburst, hsize, hwrite}, 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_pulses", {28'd0, wr_pop, rd_valid, done, err}, 32'd0);
      repeat (2) @(posedge hclk);
      #1 hreset_n = 1'b1;
      tick();

      // Single word write
      wr_data = 32'hDEAD_BEEF;
      run_cmd(1'b1, 32'h100, 8'd0, HSIZE_WORD, -10, 0, -10, lat, got_err);
      chk("wr1_latency", 32'(lat), 32'd3);
      chk("wr1_err", 32'(got_err), 32'd0);
      chk("wr1_beats", 32'(ap_addr_q.size()), 32'd1);
      check_beat(0, 32'h100, HTRANS_NONSEQ);
      chk("wr1_burst", 32'(first_burst), 32'(HBURST_SINGLE));
      chk("wr1_hwrite", 32'(first_write), 32'd1);
      chk("wr1_pops", 32'(pops), 32'd1);
      chk("wr1_mem", mem[64], 32'hDEAD_BEEF);

      // Read it back
      run_cmd(1'b0, 32'h100, 8'd0, HSIZE_WORD, -10, 0, -10, lat, got_err);
      chk("rb_latency", 32'(lat), 32'd3);
      chk("rb_count", 32'(rd_q.size()), 32'd1);
      if (rd_q.size() > 0) chk("rb_data", rd_q[0], 32'hDEAD_BEEF);

      // 4-beat INCR read, then the same read with a 2-cycle stall on beat 2
      for (int s = 0; s < 2; s++) begin
         run_cmd(1'b0, 32'h200, 8'd3, HSIZE_WORD, (s == 0) ? -10 : 2, (s == 0) ? 0 : 2, -10,
                 lat, got_err);
         chk("rd4_latency", 32'(lat), (s == 0) ? 32'd6 : 32'd8);
         chk("rd4_beats", 32'(ap_addr_q.size()), 32'd4);
         chk("rd4_burst", 32'(first_burst), 32'(HBURST_INCR));
         chk("rd4_count", 32'(rd_q.size()), 32'd4);
         for (int i = 0; i < 4; i++) begin
            check_beat(i, 32'h200 + 32'(4 * i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            if (i < rd_q.size()) chk("rd4_data", rd_q[i], 32'hA0A0_0000 + 32'(i));
         end
      end

      // 3-beat write across the 1 KB boundary
      wr_data = 32'h1111_1111;
      run_cmd(1'b1, 32'h3FC, 8'd2, HSIZE_WORD, -10, 0, -10, lat, got_err);
      chk("kb_latency", 32'(lat), 32'd5);
      chk("kb_beats", 32'(ap_addr_q.size()), 32'd3);
      check_beat(0, 32'h3FC, HTRANS_NONSEQ);
      check_beat(1, 32'h400, HTRANS_NONSEQ);
      check_beat(2, 32'h404, HTRANS_SEQ);
      chk("kb_pops", 32'(pops), 32'd3);
      chk("kb_mem0", mem[255], 32'h1111_1111);
      chk("kb_mem1", mem[256], 32'h1212_1212);
      chk("kb_mem2", mem[257], 32'h1313_1313);

      // ERROR on beat 2 data phase of a 4-beat write
      wr_data = 32'h5555_0000;
      run_cmd(1'b1, 32'h300, 8'd3, HSIZE_WORD, -10, 0, 3, lat, got_err);
      chk("er_latency", 32'(lat), 32'd5);
      chk("er_err", 32'(got_err), 32'd1);
      chk("er_beats", 32'(ap_addr_q.size()), 32'd2);
      check_beat(0, 32'h300, HTRANS_NONSEQ);
      check_beat(1, 32'h304, HTRANS_SEQ);
      chk("er_pops", 32'(pops), 32'd2);
      chk("er_mem0", mem[192], 32'h5555_0000);
      chk("er_mem1", mem[193], 32'h0);

      // Illegal size
      run_cmd(1'b1, 32'h100, 8'd0, 3'd3, -10, 0, -10, lat, got_err);
      chk("ill_latency", 32'(lat), 32'd1);
      chk("ill_err", 32'(got_err), 32'd1);
      chk("ill_beats", 32'(ap_addr_q.size()), 32'd0);
      chk("ill_pops", 32'(pops), 32'd0);

      // Byte write at an odd address
      wr_data = 32'h0000_00AB;
      run_cmd(1'b1, 32'h103, 8'd0, HSIZE_BYTE, -10, 0, -10, lat, got_err);
      chk("byte_latency", 32'(lat), 32'd3);
      chk("byte_err", 32'(got_err), 32'd0);
      chk("byte_beats", 32'(ap_addr_q.size()), 32'd1);
      check_beat(0, 32'h103, HTRANS_NONSEQ);
      chk("byte_hsize", 32'(first_size), 32'(HSIZE_BYTE));

      // Asynchronous reset in the middle of a burst
      cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 8'd3; cmd_size = HSIZE_WORD;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      hreset_n = 1'b0;
      #1;
      chk("arst_htrans", 32'(htrans), 32'd0);
      chk("arst_haddr", haddr, 32'h0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("arst_no_done", 32'(done), 32'd0);
      end
      hreset_n = 1'b1;
      tick();
      run_cmd(1'b0, 32'h204, 8'd0, HSIZE_WORD, -10, 0, -10, lat, got_err);
      chk("post_latency", 32'(lat), 32'd3);
      chk("post_count", 32'(rd_q.size()), 32'd1);
      if (rd_q.size() > 0) chk("post_data", rd_q[0], 32'hA0A0_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
AHB-Lite initiator that turns a simple command (address, beat count, size, direction) into single or INCR AHB transfers with pipelined address/data phases. It is the requester side for the team's AHB responders (on-chip RAM, peripherals) and serves as the bus engine for DMA and debug-loader blocks. It tolerates wait states, honours two-cycle ERROR responses, and splits bursts at 1 KB boundaries.

Parameters:
MAX_LEN_W, 8, width of cmd_len; maximum burst is 2^MAX_LEN_W beats.

Ports:
hclk  in  1  bus clock
hreset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  start byte address, aligned to cmd_size
cmd_len  in  MAX_LEN_W  beat count minus 1
cmd_size  in  3  AHB hsize encoding; only 0..2 legal
wr_data  in  32  write beat data, already on AHB byte lanes
wr_pop  out  1  pulse: wr_data consumed this cycle, present next beat
rd_data  out  32  read beat data
rd_valid  out  1  pulse per completed OKAY read beat
done  out  1  one-cycle pulse at command end
err  out  1  qualifies done: command ended with ERROR or illegal size
htrans  out  2  AHB transfer type
hburst  out  3  3'b000 when len = 0, else 3'b001 (INCR)
hsize  out  3  registered cmd_size
hwrite  out  1  registered cmd_write
haddr  out  32  transfer address
hwdata  out  32  write data, valid in data phase
hready  in  1  bus ready
hrdata  in  32  read data
hresp  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset: htrans = IDLE (2'b00), haddr = 0, hwdata = 0, hburst/hsize/hwrite = 0, cmd_ready = 1, wr_pop/rd_valid/done/err = 0, FSM in IDLE.
- All AHB outputs registered. Address-phase outputs change only on a cycle with hready = 1.
- FSM states:
  - IDLE: on command accept, load address, size, direction and a beat counter = cmd_len. Next state ADDR.
  - ADDR: drives the first beat as NONSEQ, later beats as SEQ. When the last address phase is accepted, go to LAST.
  - LAST: drives htrans = IDLE and waits for the final data phase with hready = 1, then returns to IDLE and pulses done.
  - ERR: see error handling.
- Illegal cmd_size (> 2): no bus activity. done = err = 1 the cycle after accept; back to IDLE.
- Address increment: haddr + (1 << hsize) per accepted beat, modulo 2^32.
- 1 KB boundary: if the next address has bits [9:0] = 0 and it is not the first beat, drive that beat as NONSEQ instead of SEQ.
- Beat acceptance: an address phase is accepted on a cycle with hready = 1 and htrans active. Beat n's data phase overlaps beat n+1's address phase.
- Write data path:
  - wr_pop = 1 in the cycle a write address phase is accepted.
  - hwdata <= wr_data at that edge and holds until the next pop.
  - A write command produces exactly cmd_len + 1 pops.
- Read data path: rd_valid = 1 and rd_data = hrdata, registered one cycle after a data phase completes with hready = 1 and hresp = 0.
- Wait states: with hready = 0, all address, control and data outputs hold, and no pop or rd_valid is issued.
- Error handling:
  - On hresp = 1 with hready = 0 (first ERROR cycle), the next-cycle htrans = IDLE, cancelling the pending address phase. Enter ERR.
  - ERR waits for hready = 1 (second ERROR cycle), then pulses done = err = 1 and returns to IDLE.
  - Remaining beats are dropped. A pop already issued for the cancelled beat is not undone.
- cmd_valid is ignored outside IDLE. Minimum command cost: single beat, no wait states = 3 cycles from accept to done.
- Asynchronous reset mid-burst: outputs go to reset values immediately and the command is lost, with no done pulse.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_SINGLE/INCR, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR, FSM state enum. Both responder and initiator blocks import it.
- No sub-module is needed. The address incrementer with boundary detect is a local function.

Test Plan:
- Single word write, addr 0x100, data 0xDEADBEEF, zero wait states, to the team's RAM -> NONSEQ/SINGLE at 0x100, one pop, done 3 cycles after accept, err = 0, readback returns 0xDEADBEEF.
- 4-beat word read at 0x200 -> NONSEQ, SEQ, SEQ, SEQ at 0x200/204/208/20C, hburst = INCR, four rd_valid pulses in address order.
- Same read with hready low for 2 cycles on beat 2 -> haddr/htrans held through the stall, rd data order unchanged, done delayed by 2 cycles.
- 3-beat word write starting at 0x3FC -> beat 2 at 0x400 driven NONSEQ, beat 3 at 0x404 SEQ, three pops.
- ERROR on data phase of beat 2 of a 4-beat write -> htrans = IDLE the cycle after the first ERROR cycle, no beat-4 address phase, done = err = 1 after the second ERROR cycle.
- cmd_size = 3 -> no htrans activity, done = err = 1 the cycle after accept. Byte write at 0x103 -> hsize = 0, haddr = 0x103.
